// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the integer register-file write side.
//   REG_AW        register address width (32 architectural registers)
//   XLEN          register data width
//   NUM_WR_PORTS  number of register-file write ports
//   WEN_WRITE     write-enable encoding for an active write
//   WEN_IDLE      write-enable encoding for an idle port
//   wb_req_t      {addr, data} pair carried from a producer to a write port
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int REG_AW       = 5;
    localparam int XLEN         = 32;
    localparam int NUM_WR_PORTS = 4;

    localparam logic [1:0] WEN_WRITE = 2'b01;
    localparam logic [1:0] WEN_IDLE  = 2'b00;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [XLEN-1:0]   data;
    } wb_req_t;

endpackage

// File: rtl/wb_prio_picker.sv
// -----------------------------------------------------------------------------
// wb_prio_picker
// Combinational priority walk for the write-back arbiter.
// Walk order: starved sources in ascending index, then all non-starved sources
// rotating from rr_ptr. A valid source is granted when fewer than NUM_WR_PORTS
// port grants exist so far and its address differs from every address already
// granted this cycle. Granted sources fill slots 0..3 in grant order.
//
// Optional feature (macro ZERO_REG_DISCARD_EN): requests to address 0 are
// acknowledged without consuming a slot and never reach a write port.
//
// Ports:
//   valid       in   per-source request valid (already reset-gated by the top)
//   addr        in   per-source destination address
//   starved     in   per-source "age at limit" flag
//   rr_ptr      in   first source of the rotating part of the walk
//   grant       out  per-source acknowledge
//   slot_used   out  slot p carries a write
//   slot_idx    out  source index feeding slot p
//   slot_count  out  number of used slots (0..4)
//   rot_hit     out  at least one grant came from the rotating part
//   rr_next     out  (last rotating grant index + 1) mod NUM_SRC
// -----------------------------------------------------------------------------
module wb_prio_picker
    import regfile_pkg::*;
#(
    parameter int NUM_SRC = 6,
    parameter int IW      = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0]      valid,
    input  logic [REG_AW-1:0]       addr [NUM_SRC],
    input  logic [NUM_SRC-1:0]      starved,
    input  logic [IW-1:0]           rr_ptr,
    output logic [NUM_SRC-1:0]      grant,
    output logic [NUM_WR_PORTS-1:0] slot_used,
    output logic [IW-1:0]           slot_idx [NUM_WR_PORTS],
    output logic [2:0]              slot_count,
    output logic                    rot_hit,
    output logic [IW-1:0]           rr_next
);

    logic [IW-1:0]     idx;
    logic [IW:0]       sum;
    logic              eligible;
    logic              clash;
    logic              take;
    logic [REG_AW-1:0] slot_addr [NUM_WR_PORTS];

    always_comb begin
        grant      = '0;
        slot_used  = '0;
        slot_count = '0;
        rot_hit    = 1'b0;
        rr_next    = rr_ptr;
        idx        = '0;
        sum        = '0;
        eligible   = 1'b0;
        clash      = 1'b0;
        take       = 1'b0;
        for (int p = 0; p < NUM_WR_PORTS; p++) begin
            slot_idx[p]  = '0;
            slot_addr[p] = '0;
        end

        // Positions 0..NUM_SRC-1 visit starved sources only; positions
        // NUM_SRC..2*NUM_SRC-1 visit the rest in rotating order. Each source
        // is therefore considered exactly once.
        for (int pos = 0; pos < 2 * NUM_SRC; pos++) begin
            if (pos < NUM_SRC) begin
                idx      = IW'(pos);
                eligible = starved[idx];
            end else begin
                sum = {1'b0, rr_ptr} + (IW+1)'(pos - NUM_SRC);
                if (sum >= (IW+1)'(NUM_SRC)) begin
                    sum = sum - (IW+1)'(NUM_SRC);
                end
                idx      = sum[IW-1:0];
                eligible = !starved[idx];
            end

            clash = 1'b0;
            for (int p = 0; p < NUM_WR_PORTS; p++) begin
                if (slot_used[p] && slot_addr[p] == addr[idx]) begin
                    clash = 1'b1;
                end
            end

            take = 1'b0;
`ifdef ZERO_REG_DISCARD_EN
            if (valid[idx] && eligible && addr[idx] == '0) begin
                take = 1'b1;
            end else
`endif
            if (valid[idx] && eligible && !clash &&
                slot_count < 3'(NUM_WR_PORTS)) begin
                take                        = 1'b1;
                slot_used[slot_count[1:0]]  = 1'b1;
                slot_idx[slot_count[1:0]]   = idx;
                slot_addr[slot_count[1:0]]  = addr[idx];
                slot_count                  = slot_count + 3'd1;
            end

            if (take) begin
                grant[idx] = 1'b1;
                // Starved grants leave the rotation pointer alone so that
                // rescuing a source does not disturb fairness of the rest.
                if (pos >= NUM_SRC) begin
                    rot_hit = 1'b1;
                    rr_next = (idx == IW'(NUM_SRC - 1)) ? '0 : idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
// Write side of the 4-write-port integer register file. Collects results from
// NUM_SRC producers over valid/ready, grants at most four per cycle with no
// duplicate destination, and drives registered write ports one cycle after the
// handshake. Starvation is bounded by per-source age counters: a source denied
// STARVE_LIMIT consecutive cycles jumps ahead of the round-robin order.
//
// Optional feature (macro ZERO_REG_DISCARD_EN): requests to x0 are acked
// immediately and never written.
//
// Ports:
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   src_valid      producer i holds a result
//   src_addr       destination of producer i at [5i+:5]
//   src_data       result of producer i at [32i+:32]
//   src_ready      combinational grant; handshake = valid & ready
//   write_addrN    registered destination address, N = 1..4
//   write_enN      2'b01 write, 2'b00 idle, N = 1..4
//   write_dataN    registered write data, N = 1..4
//   grant_count    number of writes on the ports this cycle (0..4)
// -----------------------------------------------------------------------------
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_SRC      = 6,
    parameter int STARVE_LIMIT = 7
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC*REG_AW-1:0] src_addr,
    input  logic [NUM_SRC*XLEN-1:0]   src_data,
    output logic [NUM_SRC-1:0]        src_ready,
    output logic [REG_AW-1:0]         write_addr1,
    output logic [REG_AW-1:0]         write_addr2,
    output logic [REG_AW-1:0]         write_addr3,
    output logic [REG_AW-1:0]         write_addr4,
    output logic [1:0]                write_en1,
    output logic [1:0]                write_en2,
    output logic [1:0]                write_en3,
    output logic [1:0]                write_en4,
    output logic [XLEN-1:0]           write_data1,
    output logic [XLEN-1:0]           write_data2,
    output logic [XLEN-1:0]           write_data3,
    output logic [XLEN-1:0]           write_data4,
    output logic [2:0]                grant_count
);

    localparam int IW    = $clog2(NUM_SRC);
    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

    wb_req_t                 req      [NUM_SRC];
    logic [REG_AW-1:0]       req_addr [NUM_SRC];
    logic [AGE_W-1:0]        age_reg  [NUM_SRC];
    logic [NUM_SRC-1:0]      valid_gated;
    logic [NUM_SRC-1:0]      starved;
    logic [NUM_SRC-1:0]      grant;
    logic [NUM_WR_PORTS-1:0] slot_used;
    logic [IW-1:0]           slot_idx [NUM_WR_PORTS];
    logic [2:0]              slot_count;
    logic                    rot_hit;
    logic [IW-1:0]           rr_next;
    logic [IW-1:0]           rr_ptr_reg;

    wb_req_t                 port_req_reg [NUM_WR_PORTS];
    logic [1:0]              port_en_reg  [NUM_WR_PORTS];
    logic [2:0]              grant_count_reg;

    // While reset is held no request may be acknowledged, otherwise a
    // producer would drop a result that never reaches the register file.
    assign valid_gated = src_valid & {NUM_SRC{rst_n}};
    assign src_ready   = grant;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign req[gi]      = {src_addr[gi*REG_AW +: REG_AW], src_data[gi*XLEN +: XLEN]};
            assign req_addr[gi] = req[gi].addr;
            assign starved[gi]  = (age_reg[gi] == AGE_MAX);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    age_reg[gi] <= '0;
                end else if (src_valid[gi] && !grant[gi]) begin
                    if (age_reg[gi] != AGE_MAX) begin
                        age_reg[gi] <= age_reg[gi] + 1'b1;
                    end
                end else begin
                    age_reg[gi] <= '0;
                end
            end
        end
    endgenerate

    wb_prio_picker #(
        .NUM_SRC (NUM_SRC),
        .IW      (IW)
    ) u_picker (
        .valid      (valid_gated),
        .addr       (req_addr),
        .starved    (starved),
        .rr_ptr     (rr_ptr_reg),
        .grant      (grant),
        .slot_used  (slot_used),
        .slot_idx   (slot_idx),
        .slot_count (slot_count),
        .rot_hit    (rot_hit),
        .rr_next    (rr_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg      <= '0;
            grant_count_reg <= '0;
        end else begin
            if (rot_hit) begin
                rr_ptr_reg <= rr_next;
            end
            grant_count_reg <= slot_count;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_WR_PORTS; gi++) begin : g_port
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    port_en_reg[gi]  <= WEN_IDLE;
                    port_req_reg[gi] <= '0;
                end else if (slot_used[gi]) begin
                    port_en_reg[gi]  <= WEN_WRITE;
                    port_req_reg[gi] <= req[slot_idx[gi]];
                end else begin
                    port_en_reg[gi]  <= WEN_IDLE;
                    port_req_reg[gi] <= '0;
                end
            end
        end
    endgenerate

    assign write_addr1 = port_req_reg[0].addr;
    assign write_addr2 = port_req_reg[1].addr;
    assign write_addr3 = port_req_reg[2].addr;
    assign write_addr4 = port_req_reg[3].addr;
    assign write_data1 = port_req_reg[0].data;
    assign write_data2 = port_req_reg[1].data;
    assign write_data3 = port_req_reg[2].data;
    assign write_data4 = port_req_reg[3].data;
    assign write_en1   = port_en_reg[0];
    assign write_en2   = port_en_reg[1];
    assign write_en3   = port_en_reg[2];
    assign write_en4   = port_en_reg[3];
    assign grant_count = grant_count_reg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Scoreboard bench for regfile_wb_arbiter (NUM_SRC=6, STARVE_LIMIT=7).
// The stimulus process evaluates a list-based reference of the arbitration
// rules, checks src_ready, and queues the expected port contents; a separate
// monitor pops and compares whenever the DUT shows a write.
// Honors ZERO_REG_DISCARD_EN when defined.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    localparam int N   = 6;
    localparam int LIM = 7;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    src_valid;
    logic [N*5-1:0]  src_addr;
    logic [N*32-1:0] src_data;
    logic [N-1:0]    src_ready;
    logic [4:0]      write_addr1, write_addr2, write_addr3, write_addr4;
    logic [1:0]      write_en1, write_en2, write_en3, write_en4;
    logic [31:0]     write_data1, write_data2, write_data3, write_data4;
    logic [2:0]      grant_count;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.NUM_SRC(N), .STARVE_LIMIT(LIM)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .src_valid   (src_valid),
        .src_addr    (src_addr),
        .src_data    (src_data),
        .src_ready   (src_ready),
        .write_addr1 (write_addr1),
        .write_addr2 (write_addr2),
        .write_addr3 (write_addr3),
        .write_addr4 (write_addr4),
        .write_en1   (write_en1),
        .write_en2   (write_en2),
        .write_en3   (write_en3),
        .write_en4   (write_en4),
        .write_data1 (write_data1),
        .write_data2 (write_data2),
        .write_data3 (write_data3),
        .write_data4 (write_data4),
        .grant_count (grant_count)
    );

    typedef struct packed {
        logic [2:0]        cnt;
        logic [3:0][4:0]   a;
        logic [3:0][31:0]  d;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Producer-side request state.
    logic [N-1:0] d_valid;
    logic [4:0]   d_addr [N];
    logic [31:0]  d_data [N];
    logic [N-1:0] last_ready;

    // Reference state.
    int           m_rr;
    int           m_age [N];
    logic [N-1:0] m_ready;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rr = 0;
        for (int i = 0; i < N; i++) m_age[i] = 0;
    endtask

    // One bus cycle: present requests, check ready against the reference,
    // queue the expected writes, then advance the reference to the next cycle.
    task automatic tick();
        int         order[$];
        logic [4:0] used[$];
        int         last_rot;
        int         i;
        bit         dup;
        exp_t       e;

        @(negedge clk);
        src_valid = d_valid;
        for (int k = 0; k < N; k++) begin
            src_addr[k*5 +: 5]   = d_addr[k];
            src_data[k*32 +: 32] = d_data[k];
        end
        #1;

        order = {};
        for (int k = 0; k < N; k++)
            if (m_age[k] == LIM) order.push_back(k);
        for (int k = 0; k < N; k++)
            if (m_age[(m_rr + k) % N] != LIM) order.push_back((m_rr + k) % N);

        m_ready  = '0;
        e        = '0;
        used     = {};
        last_rot = -1;
        foreach (order[o]) begin
            i = order[o];
            if (!d_valid[i]) continue;
`ifdef ZERO_REG_DISCARD_EN
            if (d_addr[i] == 5'd0) begin
                m_ready[i] = 1'b1;
                if (m_age[i] != LIM) last_rot = i;
                continue;
            end
`endif
            dup = 0;
            foreach (used[u]) if (used[u] == d_addr[i]) dup = 1;
            if (e.cnt < 4 && !dup) begin
                m_ready[i] = 1'b1;
                used.push_back(d_addr[i]);
                e.a[e.cnt] = d_addr[i];
                e.d[e.cnt] = d_data[i];
                e.cnt      = e.cnt + 3'd1;
                if (m_age[i] != LIM) last_rot = i;
            end
        end

        last_ready = src_ready;
        chk("src_ready", src_ready, m_ready);
        if (e.cnt != 0) exp_q.push_back(e);

        for (int k = 0; k < N; k++) begin
            if (d_valid[k] && !m_ready[k]) m_age[k] = (m_age[k] < LIM) ? m_age[k] + 1 : LIM;
            else                           m_age[k] = 0;
        end
        if (last_rot >= 0) m_rr = (last_rot + 1) % N;
        d_valid = d_valid & ~m_ready;
        @(posedge clk);
    endtask

    // Called just after a rising edge: drop reset while writes sit on the ports.
    task automatic reset_mid();
        #3;
        rst_n     = 1'b0;
        d_valid   = '0;
        src_valid = '0;
        #1;
        chk("rst_en1", write_en1, 2'b00);
        chk("rst_en2", write_en2, 2'b00);
        chk("rst_en3", write_en3, 2'b00);
        chk("rst_en4", write_en4, 2'b00);
        chk("rst_grant_count", grant_count, 3'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: every cycle that shows a write must match the oldest expectation.
    initial begin : monitor
        exp_t       e;
        logic [1:0]  en [4];
        logic [4:0]  ad [4];
        logic [31:0] da [4];
        forever begin
            @(posedge clk);
            #2;
            en[0] = write_en1;   en[1] = write_en2;   en[2] = write_en3;   en[3] = write_en4;
            ad[0] = write_addr1; ad[1] = write_addr2; ad[2] = write_addr3; ad[3] = write_addr4;
            da[0] = write_data1; da[1] = write_data2; da[2] = write_data3; da[3] = write_data4;
            if (en[0] != 0 || en[1] != 0 || en[2] != 0 || en[3] != 0 || grant_count != 0) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: grant_count=%0d en=%0h/%0h/%0h/%0h expected no write",
                             grant_count, en[0], en[1], en[2], en[3]);
                end else begin
                    e = exp_q.pop_front();
                    chk("grant_count", grant_count, e.cnt);
                    for (int p = 0; p < 4; p++) begin
                        if (p < int'(e.cnt)) begin
                            chk($sformatf("port%0d_en", p + 1), en[p], WEN_WRITE);
                            chk($sformatf("port%0d_addr", p + 1), ad[p], e.a[p]);
                            chk($sformatf("port%0d_data", p + 1), da[p], e.d[p]);
                        end else begin
                            chk($sformatf("port%0d_idle", p + 1), en[p], WEN_IDLE);
                        end
                    end
                    $display("txn t=%0t count=%0d p1=%0d:%08h p2=%0d:%08h p3=%0d:%08h p4=%0d:%08h",
                             $time, grant_count, ad[0], da[0], ad[1], da[1], ad[2], da[2], ad[3], da[3]);
                end
            end
        end
    end

    initial begin : stimulus
        // Asynchronous reset with every source requesting.
        rst_n     = 1'b1;
        src_valid = 6'h3F;
        for (int k = 0; k < N; k++) begin
            d_addr[k]            = 5'(k + 1);
            d_data[k]            = $urandom;
            src_addr[k*5 +: 5]   = d_addr[k];
            src_data[k*32 +: 32] = d_data[k];
        end
        d_valid = '0;
        model_reset();
        #1 rst_n = 1'b0;
        #1;
        chk("reset_ready", src_ready, 6'h00);
        chk("reset_en1", write_en1, 2'b00);
        chk("reset_en2", write_en2, 2'b00);
        chk("reset_en3", write_en3, 2'b00);
        chk("reset_en4", write_en4, 2'b00);
        chk("reset_addr1", write_addr1, 5'd0);
        chk("reset_data1", write_data1, 32'd0);
        chk("reset_grant_count", grant_count, 3'd0);
        src_valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Six requests to x1..x6 from rr_ptr=0: the first four win.
        d_valid = 6'h3F;
        tick();
        chk("t2_ready", last_ready, 6'b001111);
        tick();
        chk("t2_rest_ready", last_ready, 6'b110000);

        // Same-address collision: src0 first, src1 next cycle.
        d_valid   = 6'b000011;
        d_addr[0] = 5'd9; d_data[0] = 32'hAAAA_0000;
        d_addr[1] = 5'd9; d_data[1] = 32'hBBBB_1111;
        tick();
        chk("t3_first", last_ready, 6'b000001);
        tick();
        chk("t3_second", last_ready, 6'b000010);

        // Reset while four writes are staged on the ports.
        d_valid = 6'b001111;
        for (int k = 0; k < 4; k++) begin
            d_addr[k] = 5'(10 + k);
            d_data[k] = $urandom;
        end
        tick();
        reset_mid();
        d_valid = '0;
        tick();
        tick();

        // Starvation: src5 collides with src1 (first in rotation) every cycle
        // until its age reaches the limit, then it wins ahead of everyone.
        d_valid   = 6'b000001;
        d_addr[0] = 5'd30; d_data[0] = $urandom;
        tick();
        d_addr[5] = 5'd20;
        d_data[5] = 32'h5555_5555;
        for (int c = 0; c < 8; c++) begin
            d_valid   = 6'b100011;
            d_addr[0] = 5'($urandom_range(1, 19));
            d_data[0] = $urandom;
            d_addr[1] = 5'd20;
            d_data[1] = $urandom;
            tick();
            if (c < 7) chk("t4_src5_denied", last_ready[5], 1'b0);
            else       chk("t4_src5_granted", last_ready[5], 1'b1);
        end
        d_valid = '0;
        tick();

`ifdef ZERO_REG_DISCARD_EN
        // x0 is acked for free alongside four real writes.
        d_valid   = 6'b011111;
        d_addr[0] = 5'd0; d_data[0] = $urandom;
        for (int k = 1; k < 5; k++) begin
            d_addr[k] = 5'(k + 2);
            d_data[k] = $urandom;
        end
        tick();
        chk("t5_all_ready", last_ready, 6'b011111);
        d_valid = '0;
        tick();
`endif

        // Randomized traffic with heavy address overlap.
        for (int c = 0; c < 300; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!d_valid[k] && $urandom_range(0, 3) != 0) begin
                    d_valid[k] = 1'b1;
`ifdef ZERO_REG_DISCARD_EN
                    d_addr[k]  = 5'($urandom_range(0, 6));
`else
                    d_addr[k]  = 5'($urandom_range(1, 6));
`endif
                    d_data[k]  = $urandom;
                end
            end
            tick();
        end

        d_valid = '0;
        tick();
        tick();
        tick();
        chk("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
